legv8_multicycle_controller: RTL and testbench
==============================================

Name: legv8_multicycle_controller

Overview:
- Parametrised, handshaked successor to the LEGv8 FSM controller.
- Accepts one instruction per valid/ready handshake, latches it, and decodes it.
- Sequences the register file, ALU, data memory and branch unit through a multicycle FSM.
- Adds load-from-memory, CBZ branch, variable-latency memory wait with timeout, illegal-opcode trap and a retire pulse.
- Sits between the instruction memory/PC and the datapath.

Parameters:
- OPCODE_W, 10, opcode field width.
- REG_W, 5, register address width.
- IMM_W, 7, immediate field width.
- ALU_OP_W, 3, ALU operation code width.
- EXEC_CYCLES, 1, ALU settle cycles; must be ≥1.
- MEM_TIMEOUT, 15, max MEM-state cycles before trap; must be ≥1.
- Derived localparam: INSTR_W = OPCODE_W + IMM_W + 3*REG_W (32).
- Instruction fields, MSB first: opcode | rn | imm | rm | rd.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction word valid.
- instr_ready  out  1  controller accepts an instruction.
- instruction  in  INSTR_W  instruction word.
- alu_zero  in  1  ALU result is zero.
- mem_ready  in  1  data memory completed the access.
- mem_write_dm  out  1  data memory write.
- mem_read_dm  out  1  data memory read.
- branch  out  1  branch taken.
- reg_write_rf  out  1  register file write enable.
- mux2  out  1  1 = store data path.
- mux3  out  1  ALU operand B: 1 = register, 0 = sign-extended immediate.
- mux_wb  out  1  write-back source: 1 = memory, 0 = ALU.
- read_reg_1  out  REG_W  rn.
- read_reg_2  out  REG_W  rm.
- write_reg  out  REG_W  rd.
- sign_extension_bits  out  IMM_W  imm.
- alu_op  out  ALU_OP_W  ALU operation.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky illegal/timeout flag.
- state_dbg  out  3  current state encoding.

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-high, named `reset`.
- Reset (any state, mid-operation included):
  - state ← FETCH; latched instruction ← 0; counters ← 0; trap ← 0.
  - All 1-bit outputs 0 except instr_ready = 1.
  - Register/immediate fields 0; alu_op = 3'b101.
- Outputs are Moore: decoded from the state register and the latched instruction `iq`. Fields read_reg_1/read_reg_2/write_reg/sign_extension_bits are taken from `iq` in every state except FETCH (0 in FETCH).
- Opcodes, with alu_op / mux3 / mux2 / mux_wb:
  - ADD 1000101000: 010 / 1 / 0 / 0.
  - SUB 1100101100: 001 / 1 / 0 / 0.
  - DIV 0000011111: 011 / 1 / 0 / 0.
  - MUL 1111100000: 100 / 1 / 0 / 0.
  - LDI 1010101010: 010 / 0 / 0 / 0.
  - STUR 1111011000: 010 / 0 / 1 / 0.
  - LDUR 1111000010: 010 / 0 / 0 / 1.
  - CBZ 1011010100: 101 (pass rn) / 0 / 0 / 0.
  - Outside the decoded states, alu_op = 101.
- FETCH:
  - instr_ready = 1.
  - On instr_valid, latch instruction → DECODE.
  - instr_valid outside FETCH is ignored (instr_ready = 0).
- DECODE (1 cycle): legal opcode → EXEC; otherwise → TRAP.
- EXEC:
  - Lasts EXEC_CYCLES cycles, counted by exec_cnt.
  - Then: arithmetic/LDI → WB; STUR/LDUR → MEM; CBZ → BRANCH.
- MEM:
  - mem_write_dm (STUR) or mem_read_dm (LDUR) held high until mem_ready.
  - mem_ready is sampled each cycle, including the first MEM cycle.
  - On mem_ready: STUR asserts retire that cycle → FETCH; LDUR → WB.
  - mem_cnt counts MEM cycles. If mem_ready has not arrived by the end of cycle MEM_TIMEOUT → TRAP, with no retire.
  - If mem_ready arrives on cycle MEM_TIMEOUT, success wins.
- WB (1 cycle): reg_write_rf = 1, retire = 1 → FETCH. reg_write_rf is never high for more than one consecutive cycle.
- BRANCH (1 cycle): branch = alu_zero; retire = 1 → FETCH.
- TRAP:
  - trap = 1; instr_ready = 0; all enables 0.
  - Only reset exits.
- Throughput with instr_valid held high and EXEC_CYCLES = 1:
  - ALU op / LDI / CBZ: 4 cycles each (FETCH, DECODE, EXEC, WB/BRANCH).
  - STUR: 3 + n cycles, where n = MEM cycles.
  - LDUR: 4 + n cycles.
- State encoding on state_dbg: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRANCH 5, TRAP 7.

Test Plan:
- Reset asserted for 2 cycles, then ADD with rn=3, rm=4, rd=5 presented with instr_valid=1:
  - Required: instr_ready low from the cycle after accept; alu_op=010, mux3=1 in EXEC.
  - reg_write_rf=1 and retire=1 in the 4th cycle, write_reg=5; instr_ready high in cycle 5.
- LDI with imm=7'h2A, rd=9:
  - Required: sign_extension_bits=2A, mux3=0, alu_op=010; exactly one reg_write_rf pulse.
- LDUR with mem_ready arriving on MEM cycle 3:
  - Required: mem_read_dm high for exactly 3 cycles, then WB with mux_wb=1, then retire; 7 cycles total.
- STUR with mem_ready never asserted, MEM_TIMEOUT=15:
  - Required: mem_write_dm high for 15 cycles; trap=1 and state_dbg=7 thereafter, with no retire.
  - Reset then returns to FETCH with trap=0.
- CBZ run twice, alu_zero=1 then alu_zero=0:
  - Required: branch=1 on the first BRANCH cycle, 0 on the second; alu_op=101; one retire each.
- Opcode 10'h3FF:
  - Required: TRAP after DECODE; instruction inputs ignored.
  - Reset asserted in the EXEC of a following ADD run returns to FETCH with no reg_write_rf pulse.

Source files
------------

// File: rtl/legv8_multicycle_controller.sv
// legv8_multicycle_controller: handshaked multicycle LEGv8 control FSM with memory wait, timeout trap and retire pulse.
module legv8_multicycle_controller #(
  parameter int OPCODE_W    = 10,
  parameter int REG_W       = 5,
  parameter int IMM_W       = 7,
  parameter int ALU_OP_W    = 3,
  parameter int EXEC_CYCLES = 1,
  parameter int MEM_TIMEOUT = 15,
  localparam int INSTR_W    = OPCODE_W + IMM_W + 3*REG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_write_dm,
  output logic                mem_read_dm,
  output logic                branch,
  output logic                reg_write_rf,
  output logic                mux2,
  output logic                mux3,
  output logic                mux_wb,
  output logic [REG_W-1:0]    read_reg_1,
  output logic [REG_W-1:0]    read_reg_2,
  output logic [REG_W-1:0]    write_reg,
  output logic [IMM_W-1:0]    sign_extension_bits,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                retire,
  output logic                trap,
  output logic [2:0]          state_dbg
);
  localparam int EW = $clog2(EXEC_CYCLES + 1);
  localparam int MW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, BRANCH = 3'd5, TRAP = 3'd7
  } state_e;
  state_e             state_q, state_d;
  logic [INSTR_W-1:0] iq_q, iq_d;
  logic [EW-1:0]      exec_cnt_q, exec_cnt_d;
  logic [MW-1:0]      mem_cnt_q, mem_cnt_d;
  logic [OPCODE_W-1:0] opcode;
  logic is_add, is_sub, is_div, is_mul, is_ldi, is_stur, is_ldur, is_cbz, is_arith, legal, act, fetch;
  assign opcode   = iq_q[INSTR_W-1 -: OPCODE_W];
  assign is_add   = opcode == OPCODE_W'(10'b1000101000);
  assign is_sub   = opcode == OPCODE_W'(10'b1100101100);
  assign is_div   = opcode == OPCODE_W'(10'b0000011111);
  assign is_mul   = opcode == OPCODE_W'(10'b1111100000);
  assign is_ldi   = opcode == OPCODE_W'(10'b1010101010);
  assign is_stur  = opcode == OPCODE_W'(10'b1111011000);
  assign is_ldur  = opcode == OPCODE_W'(10'b1111000010);
  assign is_cbz   = opcode == OPCODE_W'(10'b1011010100);
  assign is_arith = is_add | is_sub | is_div | is_mul;
  assign legal    = is_arith | is_ldi | is_stur | is_ldur | is_cbz;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      iq_q       <= '0;
      exec_cnt_q <= '0;
      mem_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      iq_q       <= iq_d;
      exec_cnt_q <= exec_cnt_d;
      mem_cnt_q  <= mem_cnt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    iq_d       = iq_q;
    exec_cnt_d = exec_cnt_q;
    mem_cnt_d  = mem_cnt_q;
    case (state_q)
      FETCH: if (instr_valid) begin
        iq_d    = instruction;
        state_d = DECODE;
      end
      DECODE: begin
        state_d    = legal ? EXEC : TRAP;
        exec_cnt_d = '0;
      end
      EXEC: if (exec_cnt_q == EW'(EXEC_CYCLES - 1)) begin
        state_d   = (is_stur | is_ldur) ? MEM : is_cbz ? BRANCH : WB;
        mem_cnt_d = '0;
      end else exec_cnt_d = exec_cnt_q + EW'(1);
      // A response on the final allowed cycle still counts as success.
      MEM: if (mem_ready) state_d = is_stur ? FETCH : WB;
      else if (mem_cnt_q == MW'(MEM_TIMEOUT - 1)) state_d = TRAP;
      else mem_cnt_d = mem_cnt_q + MW'(1);
      WB, BRANCH: state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end
  assign fetch               = state_q == FETCH;
  assign act                 = !fetch && state_q != TRAP;
  assign instr_ready         = fetch;
  assign read_reg_1          = fetch ? '0 : iq_q[INSTR_W-OPCODE_W-1 -: REG_W];
  assign sign_extension_bits = fetch ? '0 : iq_q[2*REG_W+IMM_W-1 -: IMM_W];
  assign read_reg_2          = fetch ? '0 : iq_q[2*REG_W-1 -: REG_W];
  assign write_reg           = fetch ? '0 : iq_q[REG_W-1:0];
  assign alu_op = !act ? ALU_OP_W'(3'b101) : is_sub ? ALU_OP_W'(3'b001) : is_div ? ALU_OP_W'(3'b011) :
                  is_mul ? ALU_OP_W'(3'b100) : (is_add | is_ldi | is_stur | is_ldur) ? ALU_OP_W'(3'b010) :
                  ALU_OP_W'(3'b101);
  assign mux3         = act & is_arith;
  assign mux2         = act & is_stur;
  assign mux_wb       = act & is_ldur;
  assign mem_write_dm = state_q == MEM && is_stur;
  assign mem_read_dm  = state_q == MEM && is_ldur;
  assign reg_write_rf = state_q == WB;
  assign branch       = state_q == BRANCH && alu_zero;
  assign retire       = state_q == WB || state_q == BRANCH || (state_q == MEM && is_stur && mem_ready);
  assign trap         = state_q == TRAP;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// tb_legv8_multicycle_controller: table-driven decode checks plus directed multicycle sequences.
module tb_legv8_multicycle_controller;
  logic clk = 0, reset = 1, instr_valid = 0, alu_zero = 0, mem_ready = 0;
  logic [31:0] instruction = '0;
  logic instr_ready, mem_write_dm, mem_read_dm, branch, reg_write_rf, mux2, mux3, mux_wb, retire, trap;
  logic [4:0] read_reg_1, read_reg_2, write_reg;
  logic [6:0] sign_extension_bits;
  logic [2:0] alu_op, state_dbg;
  int total = 0, bad = 0;
  localparam logic [9:0] ADD = 10'b1000101000, SUB = 10'b1100101100, DIV = 10'b0000011111,
    MUL = 10'b1111100000, LDI = 10'b1010101010, STUR = 10'b1111011000, LDUR = 10'b1111000010,
    CBZ = 10'b1011010100, BAD = 10'h3FF;
  legv8_multicycle_controller dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_write_dm(mem_write_dm), .mem_read_dm(mem_read_dm), .branch(branch),
    .reg_write_rf(reg_write_rf), .mux2(mux2), .mux3(mux3), .mux_wb(mux_wb),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .write_reg(write_reg),
    .sign_extension_bits(sign_extension_bits), .alu_op(alu_op), .retire(retire),
    .trap(trap), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0] op;
    logic [2:0] alu;
    logic       m3, m2, mwb;
    logic [2:0] nxt;
  } vec_t;
  vec_t tv[9];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    instr_valid = 0;
    mem_ready = 0;
    tick();
    tick();
    reset = 0;
  endtask
  function automatic logic [31:0] mk(input logic [9:0] op, input logic [4:0] rn, input logic [6:0] imm,
                                     input logic [4:0] rm, input logic [4:0] rd);
    return {op, rn, imm, rm, rd};
  endfunction
  initial begin
    int n, m, r, cyc;
    logic wb_ok;
    tv[0] = '{ADD,  3'b010, 1, 0, 0, 3'd4};
    tv[1] = '{SUB,  3'b001, 1, 0, 0, 3'd4};
    tv[2] = '{DIV,  3'b011, 1, 0, 0, 3'd4};
    tv[3] = '{MUL,  3'b100, 1, 0, 0, 3'd4};
    tv[4] = '{LDI,  3'b010, 0, 0, 0, 3'd4};
    tv[5] = '{STUR, 3'b010, 0, 1, 0, 3'd3};
    tv[6] = '{LDUR, 3'b010, 0, 0, 1, 3'd3};
    tv[7] = '{CBZ,  3'b101, 0, 0, 0, 3'd5};
    tv[8] = '{BAD,  3'b101, 0, 0, 0, 3'd7};
    do_reset();
    chk("rst_state", state_dbg, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_alu_op", alu_op, 3'b101);
    chk("rst_outs", {mem_write_dm, mem_read_dm, branch, reg_write_rf, mux2, mux3, mux_wb, retire, trap}, 0);
    chk("rst_fields", {read_reg_1, read_reg_2, write_reg, sign_extension_bits}, 0);
    for (int i = 0; i < 9; i++) begin
      do_reset();
      instruction = mk(tv[i].op, 5'd1, 7'h12, 5'd3, 5'd4);
      instr_valid = 1;
      chk("tv_ready_fetch", instr_ready, 1);
      tick();
      instr_valid = 0;
      chk("tv_decode", state_dbg, 1);
      chk("tv_ready_decode", instr_ready, 0);
      tick();
      if (tv[i].nxt == 3'd7) begin
        chk("tv_trap_state", state_dbg, 7);
        chk("tv_trap", trap, 1);
        chk("tv_trap_retire", retire, 0);
      end else begin
        chk("tv_exec", state_dbg, 2);
        chk("tv_alu_op", alu_op, tv[i].alu);
        chk("tv_muxes", {mux3, mux2, mux_wb}, {tv[i].m3, tv[i].m2, tv[i].mwb});
        chk("tv_fields", {read_reg_1, read_reg_2, write_reg, sign_extension_bits}, {5'd1, 5'd3, 5'd4, 7'h12});
        tick();
        chk("tv_next", state_dbg, tv[i].nxt);
      end
    end
    do_reset();
    instruction = mk(ADD, 5'd3, 7'd0, 5'd4, 5'd5);
    instr_valid = 1;
    chk("add_c1_ready", instr_ready, 1);
    tick();
    chk("add_c2_ready", instr_ready, 0);
    tick();
    chk("add_c3_alu", {alu_op, mux3}, {3'b010, 1'b1});
    tick();
    chk("add_c4_wb", {reg_write_rf, retire, write_reg}, {1'b1, 1'b1, 5'd5});
    instr_valid = 0;
    tick();
    chk("add_c5", {instr_ready, reg_write_rf, state_dbg}, {1'b1, 1'b0, 3'd0});
    do_reset();
    instruction = mk(LDI, 5'd0, 7'h2A, 5'd0, 5'd9);
    instr_valid = 1;
    tick();
    instr_valid = 0;
    tick();
    chk("ldi_exec", {sign_extension_bits, mux3, alu_op}, {7'h2A, 1'b0, 3'b010});
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += reg_write_rf;
      tick();
    end
    chk("ldi_wr_pulses", n, 1);
    do_reset();
    instruction = mk(LDUR, 5'd2, 7'h04, 5'd0, 5'd6);
    instr_valid = 1;
    n = 0; m = 0; r = 0; cyc = 0; wb_ok = 0;
    for (int i = 0; i < 30; i++) begin
      cyc++;
      if (state_dbg == 3) begin
        m++;
        mem_ready = (m == 3);
      end else mem_ready = 0;
      n += mem_read_dm;
      r += retire;
      if (state_dbg == 4) wb_ok = mux_wb & retire & reg_write_rf & (write_reg == 5'd6);
      tick();
      instr_valid = 0;
      if (state_dbg == 0) break;
    end
    mem_ready = 0;
    chk("ldur_rd_cycles", n, 3);
    chk("ldur_wb", wb_ok, 1);
    chk("ldur_retires", r, 1);
    chk("ldur_total", cyc, 7);
    do_reset();
    instruction = mk(STUR, 5'd1, 7'h00, 5'd2, 5'd0);
    instr_valid = 1;
    n = 0; r = 0;
    for (int i = 0; i < 40; i++) begin
      n += mem_write_dm;
      r += retire;
      tick();
      instr_valid = 0;
    end
    chk("stur_wr_cycles", n, 15);
    chk("stur_retires", r, 0);
    chk("stur_trap", {trap, state_dbg, instr_ready}, {1'b1, 3'd7, 1'b0});
    do_reset();
    chk("stur_rst", {trap, state_dbg, instr_ready}, {1'b0, 3'd0, 1'b1});
    for (int k = 0; k < 2; k++) begin
      alu_zero = (k == 0);
      instruction = mk(CBZ, 5'd7, 7'h10, 5'd0, 5'd0);
      instr_valid = 1;
      n = 0; r = 0; m = 0;
      for (int i = 0; i < 4; i++) begin
        r += retire;
        if (state_dbg == 5) begin
          m++;
          chk("cbz_branch", branch, alu_zero);
          chk("cbz_alu_op", alu_op, 3'b101);
        end
        tick();
        instr_valid = 0;
      end
      chk("cbz_retires", r, 1);
      chk("cbz_branch_cycles", m, 1);
    end
    do_reset();
    instruction = mk(BAD, 5'd0, 7'd0, 5'd0, 5'd0);
    instr_valid = 1;
    tick();
    tick();
    chk("bad_trap", {trap, state_dbg}, {1'b1, 3'd7});
    instruction = mk(ADD, 5'd1, 7'd0, 5'd2, 5'd3);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      n += instr_ready | retire | reg_write_rf | (state_dbg != 3'd7);
      tick();
    end
    chk("bad_ignored", n, 0);
    do_reset();
    instr_valid = 1;
    tick();
    instr_valid = 0;
    tick();
    chk("abort_exec", state_dbg, 2);
    reset = 1;
    n = 0;
    tick();
    n += reg_write_rf;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      n += reg_write_rf;
      tick();
    end
    chk("abort_no_wr", n, 0);
    chk("abort_fetch", {state_dbg, instr_ready}, {3'd0, 1'b1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
